// File: rtl/cs_resolve.sv
// cs_resolve: turns a carry-save pair (r0, r1) into a plain binary sum.
// The two words are added CHUNK bits per cycle through one narrow adder,
// least significant chunk first, with the carry held in a flop between
// chunks. The result is published on s/cout together with a one-cycle
// en_out pulse.
//
// Handshake: en is a start request. It is taken only when the block is
// IDLE or DONE (busy low); r0/r1 are captured on that same edge and may
// change freely afterwards. en raised while busy is dropped, with no effect.
// en_out marks the single cycle in which a fresh s/cout first appears.
// s/cout then hold that value until the next completion.
module cs_resolve #(
  parameter int WIDTH = 3152,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             en_out,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   op0;
  logic [PW-1:0]   op1;
  // Chunks already produced. The newest chunk enters at the top, so after
  // the last add the full result sits in acc_next.
  logic [PW-CHUNK-1:0] acc;
  logic            carry;
  logic [CW-1:0]   cnt;

  logic [CHUNK:0]  sum;
  logic [PW-1:0]   acc_next;
  logic            cout_next;
  logic            last;

  // One chunk-wide add per cycle, plus the assembled accumulator.
  always_comb begin
    sum      = {1'b0, op0[CHUNK-1:0]} + {1'b0, op1[CHUNK-1:0]}
             + {{CHUNK{1'b0}}, carry};
    acc_next = {sum[CHUNK-1:0], acc};
    last     = (cnt == CW'(NCHUNK - 1));
  end

  // When WIDTH fills the last chunk exactly, bit WIDTH of the sum is the
  // carry out of the final add. Otherwise it lands inside the padding of
  // the top chunk, which is zero, so it comes from the accumulator.
  generate
    if (WIDTH % CHUNK == 0) begin : g_cout_carry
      assign cout_next = sum[CHUNK];
    end else begin : g_cout_acc
      assign cout_next = acc_next[WIDTH];
    end
  endgenerate

  assign dbg_state = state;

  // Control FSM and datapath registers. Every output is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      s      <= '0;
      cout   <= 1'b0;
      en_out <= 1'b0;
      busy   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      en_out <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (en) begin
            op0   <= PW'(r0);
            op1   <= PW'(r1);
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          op0   <= op0 >> CHUNK;
          op1   <= op1 >> CHUNK;
          acc   <= acc_next[PW-1:CHUNK];
          carry <= sum[CHUNK];
          cnt   <= cnt + CW'(1);
          if (last) begin
            s      <= acc_next[WIDTH-1:0];
            cout   <= cout_next;
            en_out <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
